// File: rtl/serial_parity_rx_pkg.sv
// Shared types and helpers for the serial parity frame receiver.
// Also intended for the matching transmitter.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int MAX_DATA_W = 16;

    // Parity bit that completes vec under even (odd=0) or odd (odd=1) parity.
    function automatic logic parity_of(
        input logic [MAX_DATA_W-1:0] vec,
        input logic                  odd
    );
        return (^vec) ^ odd;
    endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Serial line in, checked word and flags out.
// Optional err_count when SERIAL_PARITY_RX_ERR_CNT_EN is defined.
interface serial_parity_rx_if #(
    parameter int DATA_W = 3
);
    import serial_parity_pkg::*;

    logic              rx_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    logic [7:0]        err_count;
`endif

    modport master (
        output rx_in,
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
        input  err_count,
`endif
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_in,
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
        output err_count,
`endif
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/serial_parity_rx_parity_accum.sv
// 1-bit running XOR with clear-to-seed and enable.
// Shared between the frame receiver and a future transmitter.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic seed,
    input  logic en,
    input  logic d,
    output logic par
);

    logic par_d;
    logic par_q;

    // Clear has priority so a new frame always starts from the seed.
    always_comb begin
        par_d = par_q;
        if (clr) begin
            par_d = seed;
        end else if (en) begin
            par_d = par_q ^ d;
        end
    end

    // Running parity register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par = par_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, parity, stop.
// Define SERIAL_PARITY_RX_ERR_CNT_EN to add a saturating error counter.
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_parity_rx_if.slave  bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    logic              par_clr;
    logic              par_en;
    logic              par;

    // After the parity bit is folded in, par is 1 exactly on a mismatch.
    parity_accum u_parity_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (par_clr),
        .seed  (ODD_PARITY),
        .en    (par_en),
        .d     (bus.rx_in),
        .par   (par)
    );

    // Next-state, shift and flag computation; flags default to 0 for pulses.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        par_clr      = 1'b0;
        par_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.rx_in == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                    par_clr = 1'b1;
                end
            end
            DATA: begin
                shift_d[cnt_q] = bus.rx_in;
                par_en         = 1'b1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                par_en  = 1'b1;
                state_d = STOP;
            end
            STOP: begin
                if (bus.rx_in == STOP_BIT) begin
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                    parity_err_d = par;
                end else begin
                    frame_err_d  = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count each error pulse as it is issued, saturating at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((parity_err_d || frame_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx with a scoreboard of expected frames.
// Unit 0 is even parity, unit 1 is odd parity.
module tb_serial_parity_rx;

    typedef struct {
        logic [2:0] data;
        logic       dv;
        logic       pe;
        logic       fe;
        int         gap;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rx0;
    logic rx1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_pulse [2];
    logic [2:0] last_good [2];

    exp_t q0 [$];
    exp_t q1 [$];

    serial_parity_rx_if #(.DATA_W(3)) if0 ();
    serial_parity_rx_if #(.DATA_W(3)) if1 ();

    assign if0.rx_in = rx0;
    assign if1.rx_in = rx1;

    serial_parity_rx #(.DATA_W(3), .ODD_PARITY(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    serial_parity_rx #(.DATA_W(3), .ODD_PARITY(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe(input int u, input logic [2:0] dout,
                           input logic dv, input logic pe, input logic fe);
        exp_t e;
        int   n;
        n = (u == 0) ? q0.size() : q1.size();
        check($sformatf("u%0d_expected_pending", u), 32'(n != 0), 32'd1);
        if (n != 0) begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("u%0d_data_out", u), 32'(dout), 32'(e.data));
            check($sformatf("u%0d_data_valid", u), 32'(dv), 32'(e.dv));
            check($sformatf("u%0d_parity_err", u), 32'(pe), 32'(e.pe));
            check($sformatf("u%0d_frame_err", u), 32'(fe), 32'(e.fe));
            if (e.gap != 0) begin
                check($sformatf("u%0d_pulse_gap", u),
                      32'(cyc - last_pulse[u]), 32'(e.gap));
            end
        end
        last_pulse[u] = cyc;
    endtask

    always @(negedge clk) begin
        if (rst_n && (if0.data_valid || if0.frame_err)) begin
            observe(0, if0.data_out, if0.data_valid,
                    if0.parity_err, if0.frame_err);
        end
    end

    always @(negedge clk) begin
        if (rst_n && (if1.data_valid || if1.frame_err)) begin
            observe(1, if1.data_out, if1.data_valid,
                    if1.parity_err, if1.frame_err);
        end
    end

    task automatic drive(input int u, input logic b);
        if (u == 0) rx0 = b;
        else        rx1 = b;
    endtask

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(u, 1'b1);
        end
    endtask

    task automatic send(input int u, input logic [2:0] d, input logic pb,
                        input logic sb, input int gap);
        exp_t       e;
        logic [5:0] bits;
        logic       odd;
        odd  = (u == 1);
        bits = {sb, pb, d, 1'b0};
        e.gap = gap;
        e.dv  = sb;
        e.fe  = ~sb;
        if (sb) begin
            e.data       = d;
            e.pe         = ((d[0] ^ d[1] ^ d[2] ^ pb) != odd);
            last_good[u] = d;
        end else begin
            e.data = last_good[u];
            e.pe   = 1'b0;
        end
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check($sformatf("u%0d_busy_in_frame", u),
                      32'((u == 0) ? if0.busy : if1.busy), 32'd1);
            end
            drive(u, bits[i]);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        rx0          = 1'b1;
        rx1          = 1'b1;
        last_pulse   = '{0, 0};
        last_good    = '{3'd0, 3'd0};

        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(if0.data_out), 32'd0);
        check("reset_data_valid", 32'(if0.data_valid), 32'd0);
        check("reset_parity_err", 32'(if0.parity_err), 32'd0);
        check("reset_frame_err", 32'(if0.frame_err), 32'd0);
        check("reset_busy", 32'(if0.busy), 32'd0);
        check("reset_busy_u1", 32'(if1.busy), 32'd0);
        rst_n = 1'b1;
        idle(0, 2);
        check("idle_busy", 32'(if0.busy), 32'd0);

        // good even-parity frame 101
        send(0, 3'b101, 1'b0, 1'b1, 0);
        idle(0, 3);
        check("idle_after_frame_busy", 32'(if0.busy), 32'd0);

        // bad parity bit; flags clear the following cycle
        send(0, 3'b101, 1'b1, 1'b1, 0);
        idle(0, 2);
        check("parity_err_cleared", 32'(if0.parity_err), 32'd0);
        check("data_valid_cleared", 32'(if0.data_valid), 32'd0);
        idle(0, 2);

        // stop bit 0: frame error, data_out holds 101
        send(0, 3'b011, 1'b0, 1'b0, 0);
        idle(0, 2);
        check("frame_err_cleared", 32'(if0.frame_err), 32'd0);
        check("data_out_held", 32'(if0.data_out), 32'd5);
        idle(0, 2);

        // back-to-back sweep, even parity
        for (int v = 0; v < 8; v++) begin
            logic [2:0] d;
            d = 3'(v);
            send(0, d, d[0] ^ d[1] ^ d[2], 1'b1, (v == 0) ? 0 : 6);
        end
        idle(0, 4);

        // back-to-back sweep, odd parity
        for (int v = 0; v < 8; v++) begin
            logic [2:0] d;
            d = 3'(v);
            send(1, d, ~(d[0] ^ d[1] ^ d[2]), 1'b1, (v == 0) ? 0 : 6);
        end
        idle(1, 4);

        // reset after two data bits of frame 010
        @(negedge clk); rx0 = 1'b0;
        @(negedge clk); rx0 = 1'b0;
        @(negedge clk); rx0 = 1'b1;
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(if0.busy), 32'd0);
        check("midreset_data_out", 32'(if0.data_out), 32'd0);
        last_good = '{3'd0, 3'd0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(0, 6);
        check("after_abort_busy", 32'(if0.busy), 32'd0);
        check("after_abort_valid", 32'(if0.data_valid), 32'd0);
        send(0, 3'b010, 1'b1, 1'b1, 0);
        idle(0, 4);

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
        check("err_count_after_reset", 32'(if0.err_count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            send(0, 3'b110, 1'b1, 1'b1, 0);
        end
        send(0, 3'b001, 1'b1, 1'b0, 0);
        idle(0, 4);
        check("err_count_four", 32'(if0.err_count), 32'd4);
        for (int k = 0; k < 300; k++) begin
            send(0, 3'b000, 1'b0, 1'b0, 0);
        end
        idle(0, 4);
        check("err_count_saturated", 32'(if0.err_count), 32'd255);
`endif

        idle(0, 8);
        check("u0_all_frames_seen", 32'(q0.size()), 32'd0);
        check("u1_all_frames_seen", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
